serial_subtractor: RTL

Bit-serial subtractor, the inverse arithmetic direction of the team's full-adder cell. It computes diff = a - b over WIDTH clock cycles, one bit per cycle, LSB first. A combinational full-subtractor cell is reused on every cycle, with the borrow held in a flop between cycles. A start/busy/done handshake lets a bench or controller launch operations and collect results.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding for the bit-serial subtractor
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
//
// Ports:
//   x     minuend bit
//   y     subtrahend bit
//   b_in  borrow from the less significant bit
//   diff  x - y - b_in, modulo 2
//   b_out borrow into the next more significant bit
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = x ^ y ^ b_in;
    // Borrow when y beats x outright, or when x == y and a borrow is
    // already pending from below.
    assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, with start/busy/done handshake
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        launch request, honoured only while idle
//   a, b         operands, captured on the accepted start cycle
//   busy         high while an operation is in flight
//   done         one-cycle pulse when diff/borrow_out are updated
//   diff         (a - b) mod 2^WIDTH, held until the next result
//   borrow_out   1 iff a < b (unsigned), held with diff
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bq_q, bq_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             bo_bit;

    full_subtractor u_cell (
        .x     (sa_q[0]),
        .y     (sb_q[0]),
        .b_in  (bq_q),
        .diff  (d_bit),
        .b_out (bo_bit)
    );

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        res_d        = res_q;
        bq_d         = bq_q;
        count_d      = count_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    res_d   = '0;
                    bq_d    = 1'b0;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                // Result bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) difference bit has reached position 0.
                res_d = {d_bit, res_q[WIDTH-1:1]};
                bq_d  = bo_bit;
                if (count_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // bq_q now holds the borrow out of the MSB.
                diff_d       = res_q;
                borrow_out_d = bq_q;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            bq_q         <= 1'b0;
            count_q      <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            res_q        <= res_d;
            bq_q         <= bq_d;
            count_q      <= count_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
